poli_apb_arbiter: RTL and testbench

//  Round-robin arbiter and APB master sequencer that shares the single POLI_top_level
//  APB slave port between NREQ on-chip requesters (e.g. CRC driver, NAND/NOR and XOR/BUF exercisers).

---
 rtl/POLI_types_pkg.sv | 21 ++
 rtl/poli_rr_picker.sv | 39 +++
 rtl/poli_apb_arbiter.sv | 144 ++++++++++++++
 tb/tb_poli_apb_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/POLI_types_pkg.sv
// POLI_types_pkg
//  Shared types and constants for the POLI top level and its on-chip masters.
//  - WORD_SIZE            : data/address width of the POLI APB slave port
//  - CRC_CONFIG_ADDR      : register address of the CRC configuration word
//  - ARB_TIMEOUT_DEFAULT  : default PREADY wait limit of the APB arbiter
//  - apb_arb_state_t      : state encoding of the APB arbiter sequencer
package POLI_types_pkg;

    localparam int WORD_SIZE = 32;

    localparam logic [WORD_SIZE-1:0] CRC_CONFIG_ADDR = 32'h0000_0010;

    localparam int ARB_TIMEOUT_DEFAULT = 256;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SETUP,
        ARB_ACCESS
    } apb_arb_state_t;

endpackage

// File: rtl/poli_rr_picker.sv
// poli_rr_picker
//  Combinational round-robin selector. Scans the request vector starting at
//  ptr and moving upward with wrap-around; the first set bit wins.
//  Ports:
//   req    in  NREQ    request vector
//   ptr    in  PTR_W   index with the highest priority this round
//   valid  out 1       at least one request is set
//   grant  out PTR_W   index of the winning request (0 when valid=0)
module poli_rr_picker #(
    parameter int NREQ  = 2,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [PTR_W-1:0] grant
);

    always_comb begin
        int  idx;
        logic found;
        valid = |req;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        // Offset k from ptr; the smallest offset with a request wins.
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                grant = idx[PTR_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/poli_apb_arbiter.sv
// poli_apb_arbiter
//  Shares the single POLI APB slave port between NREQ requesters. A requester
//  holds req high until it sees its done pulse; the arbiter grants in
//  round-robin order, runs SETUP/ACCESS, waits for PREADY and returns the read
//  data with a one-cycle done. An ACCESS phase that never sees PREADY is
//  aborted after TIMEOUT cycles and reported with err=1.
//  Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   req/req_write             per-requester request level and direction
//   req_addr/req_wdata        flattened per-requester address / write data
//   done, err, rdata          completion pulse, timeout flag, read data
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB master outputs
//   PRDATA/PREADY             APB slave responses
module poli_apb_arbiter
    import POLI_types_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           req_write,
    input  logic [NREQ*WORD_SIZE-1:0] req_addr,
    input  logic [NREQ*WORD_SIZE-1:0] req_wdata,
    output logic [NREQ-1:0]           done,
    output logic                      err,
    output logic [WORD_SIZE-1:0]      rdata,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [WORD_SIZE-1:0]      PADDR,
    output logic [WORD_SIZE-1:0]      PWDATA,
    input  logic [WORD_SIZE-1:0]      PRDATA,
    input  logic                      PREADY
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_arb_state_t   state_reg;
    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] gnt_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [WORD_SIZE-1:0] addr_arr  [NREQ];
    logic [WORD_SIZE-1:0] wdata_arr [NREQ];

    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic [NREQ-1:0]  gnt_onehot;
    logic [PTR_W-1:0] ptr_next;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign addr_arr[gi]  = req_addr[gi*WORD_SIZE +: WORD_SIZE];
        assign wdata_arr[gi] = req_wdata[gi*WORD_SIZE +: WORD_SIZE];
    end

    poli_rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .grant (pick_idx)
    );

    assign gnt_onehot = {{(NREQ-1){1'b0}}, 1'b1} << gnt_reg;

    // After serving g, g+1 becomes top priority so a continuously requesting
    // peer cannot be starved.
    assign ptr_next = (gnt_reg == PTR_W'(NREQ - 1)) ? '0 : gnt_reg + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ARB_IDLE;
            ptr_reg   <= '0;
            gnt_reg   <= '0;
            cnt_reg   <= '0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
        end else begin
            // done/err are single-cycle pulses.
            done <= '0;
            err  <= 1'b0;
            case (state_reg)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        gnt_reg   <= pick_idx;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        PWRITE    <= req_write[pick_idx];
                        PADDR     <= addr_arr[pick_idx];
                        PWDATA    <= wdata_arr[pick_idx];
                        state_reg <= ARB_SETUP;
                    end
                end

                ARB_SETUP: begin
                    PENABLE   <= 1'b1;
                    cnt_reg   <= '0;
                    state_reg <= ARB_ACCESS;
                end

                ARB_ACCESS: begin
                    // PREADY wins over the timeout on the last allowed cycle.
                    if (PREADY || (cnt_reg == CNT_LAST)) begin
                        done <= gnt_onehot;
                        err  <= ~PREADY;
                        if (!PREADY) begin
                            rdata <= '0;
                        end else if (!PWRITE) begin
                            rdata <= PRDATA;
                        end
                        ptr_reg   <= ptr_next;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        PWRITE    <= 1'b0;
                        PADDR     <= '0;
                        PWDATA    <= '0;
                        state_reg <= ARB_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                default: begin
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poli_apb_arbiter.sv
// tb_poli_apb_arbiter
//  Directed table of transfers, hand-written reset / late-drop sequences and
//  a randomized phase checked against a transaction-level round-robin model.
module tb_poli_apb_arbiter;
    import POLI_types_pkg::*;

    localparam int N  = 3;
    localparam int TO = 8;
    localparam int W  = WORD_SIZE;

    logic             CLK;
    logic             RST;
    logic [N-1:0]     req;
    logic [N-1:0]     req_write;
    logic [N*W-1:0]   req_addr;
    logic [N*W-1:0]   req_wdata;
    logic [N-1:0]     done;
    logic             err;
    logic [W-1:0]     rdata;
    logic             PSEL;
    logic             PENABLE;
    logic             PWRITE;
    logic [W-1:0]     PADDR;
    logic [W-1:0]     PWDATA;
    logic [W-1:0]     PRDATA;
    logic             PREADY;

    int total;
    int bad;

    logic         w_v [N];
    logic [W-1:0] a_v [N];
    logic [W-1:0] d_v [N];

    poli_apb_arbiter #(
        .NREQ    (N),
        .TIMEOUT (TO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] ctl_now();
        return 128'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, done, err});
    endfunction

    function automatic logic [127:0] ctl_exp(input logic s, input logic e, input logic w,
                                             input logic [W-1:0] a, input logic [W-1:0] d,
                                             input logic [N-1:0] dn, input logic er);
        return 128'({s, e, w, a, d, dn, er});
    endfunction

    task automatic set_fields(input int i, input logic w, input logic [W-1:0] a, input logic [W-1:0] d);
        w_v[i] = w;
        a_v[i] = a;
        d_v[i] = d;
        req_write[i]       = w;
        req_addr[i*W +: W] = a;
        req_wdata[i*W +: W] = d;
    endtask

    // Round-robin rule: first pending requester at or after p, wrapping.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One complete transfer starting from an idle arbiter with req already
    // presented. The slave answers PREADY on ACCESS cycle waits+1.
    task automatic xfer(input string tag, input int g, input logic w,
                        input logic [W-1:0] a, input logic [W-1:0] d,
                        input int waits, input logic [W-1:0] prd,
                        input logic [N-1:0] clr_setup, input logic [N-1:0] set_access,
                        input logic exp_err, input logic [W-1:0] exp_rd);
        logic [N-1:0] oh;
        oh    = '0;
        oh[g] = 1'b1;
        PREADY = 1'($urandom_range(0, 1));
        PRDATA = $urandom;
        tick();
        chk({tag, " setup"}, ctl_now(), ctl_exp(1'b1, 1'b0, w, a, d, '0, 1'b0));
        req    = req & ~clr_setup;
        PREADY = 1'($urandom_range(0, 1));
        PRDATA = $urandom;
        tick();
        chk({tag, " access"}, ctl_now(), ctl_exp(1'b1, 1'b1, w, a, d, '0, 1'b0));
        req = req | set_access;
        for (int k = 1; k <= TO; k++) begin
            PREADY = (k == waits + 1);
            PRDATA = (k == waits + 1) ? prd : $urandom;
            tick();
            if ((k == waits + 1) || (k == TO)) break;
            chk($sformatf("%s wait%0d", tag, k), ctl_now(), ctl_exp(1'b1, 1'b1, w, a, d, '0, 1'b0));
        end
        PREADY = 1'b0;
        PRDATA = $urandom;
        chk({tag, " done"}, ctl_now(), ctl_exp(1'b0, 1'b0, 1'b0, '0, '0, oh, exp_err));
        chk({tag, " rdata"}, 128'(rdata), 128'(exp_rd));
        $display("xfer %s: g=%0d w=%0d addr=%h waits=%0d err=%0d rdata=%h", tag, g, w, a, waits, err, rdata);
    endtask

    typedef struct {
        logic [N-1:0] req;
        int           who;
        logic         w;
        logic [W-1:0] a;
        logic [W-1:0] d;
        int           waits;
        logic [W-1:0] prd;
        logic         hold;
        int           exp_g;
        logic         exp_err;
        logic [W-1:0] exp_rd;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           ptr_m;
        logic [W-1:0] rd_m;

        total = 0;
        bad   = 0;
        RST   = 1'b1;
        req   = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA = '0;
        PREADY = 1'b0;
        for (int i = 0; i < N; i++) set_fields(i, 1'b0, '0, '0);

        tbl[0]  = '{3'b001, 0, 1'b1, CRC_CONFIG_ADDR, 32'hDEADBEEF, 0,      32'h0,        1'b0, 0, 1'b0, 32'h0};
        tbl[1]  = '{3'b010, 1, 1'b0, 32'h0000_0020,   32'h0,        2,      32'h0000_00A5, 1'b0, 1, 1'b0, 32'h0000_00A5};
        tbl[2]  = '{3'b011, 0, 1'b1, 32'h0000_0100,   32'h1111_1111, 0,     32'h0,        1'b1, 0, 1'b0, 32'h0000_00A5};
        tbl[3]  = '{3'b011, 1, 1'b1, 32'h0000_0104,   32'h2222_2222, 1,     32'h0,        1'b1, 1, 1'b0, 32'h0000_00A5};
        tbl[4]  = '{3'b011, 0, 1'b1, 32'h0000_0108,   32'h3333_3333, 3,     32'h0,        1'b1, 0, 1'b0, 32'h0000_00A5};
        tbl[5]  = '{3'b011, 1, 1'b1, 32'h0000_010C,   32'h4444_4444, 0,     32'h0,        1'b0, 1, 1'b0, 32'h0000_00A5};
        tbl[6]  = '{3'b100, 2, 1'b0, 32'h0000_0200,   32'h0,        TO + 3, 32'hFFFF_FFFF, 1'b0, 2, 1'b1, 32'h0};
        tbl[7]  = '{3'b100, 2, 1'b0, 32'h0000_0204,   32'h0,        TO - 1, 32'h5A5A_0007, 1'b0, 2, 1'b0, 32'h5A5A_0007};
        tbl[8]  = '{3'b101, 0, 1'b1, 32'h0000_0300,   32'hABCD_0000, TO - 2, 32'h0,       1'b0, 0, 1'b0, 32'h5A5A_0007};
        tbl[9]  = '{3'b100, 2, 1'b0, 32'h0000_0208,   32'h0,        0,      32'hCAFE_F00D, 1'b0, 2, 1'b0, 32'hCAFE_F00D};
        tbl[10] = '{3'b111, 0, 1'b1, 32'h0000_0400,   32'h0000_0001, 0,     32'h0,        1'b1, 0, 1'b0, 32'hCAFE_F00D};
        tbl[11] = '{3'b111, 1, 1'b1, 32'h0000_0404,   32'h0000_0002, 0,     32'h0,        1'b1, 1, 1'b0, 32'hCAFE_F00D};
        tbl[12] = '{3'b111, 2, 1'b1, 32'h0000_0408,   32'h0000_0003, 0,     32'h0,        1'b0, 2, 1'b0, 32'hCAFE_F00D};

        tick();
        tick();
        chk("reset ctl", ctl_now(), ctl_exp(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0));
        chk("reset rdata", 128'(rdata), 128'(0));
        RST = 1'b0;

        // Directed table
        for (int r = 0; r < 13; r++) begin
            req = tbl[r].req;
            set_fields(tbl[r].who, tbl[r].w, tbl[r].a, tbl[r].d);
            xfer($sformatf("tbl%0d", r), tbl[r].exp_g, tbl[r].w, tbl[r].a, tbl[r].d,
                 tbl[r].waits, tbl[r].prd, '0, '0, tbl[r].exp_err, tbl[r].exp_rd);
            if (!tbl[r].hold) req[tbl[r].exp_g] = 1'b0;
        end

        // Late drop of req[1] in SETUP; req[0] raised during ACCESS.
        req = 3'b010;
        set_fields(0, 1'b1, 32'h0000_0500, 32'h0BAD_CAFE);
        set_fields(1, 1'b0, 32'h0000_0504, 32'h0);
        xfer("late drop", 1, 1'b0, 32'h0000_0504, 32'h0, 1, 32'h1234_5678,
             3'b010, 3'b001, 1'b0, 32'h1234_5678);
        chk("late drop req", 128'(req), 128'(3'b001));
        xfer("late arrival", 0, 1'b1, 32'h0000_0500, 32'h0BAD_CAFE, 0, 32'h0,
             '0, '0, 1'b0, 32'h1234_5678);
        req[0] = 1'b0;

        // Reset mid-ACCESS with ptr=2; afterwards requester 1 must win over 2.
        req = 3'b010;
        set_fields(1, 1'b1, 32'h0000_0508, 32'h0000_0055);
        xfer("pre reset", 1, 1'b1, 32'h0000_0508, 32'h0000_0055, 0, 32'h0,
             '0, '0, 1'b0, 32'h1234_5678);
        req = 3'b100;
        set_fields(2, 1'b1, 32'h0000_0600, 32'h0000_0077);
        PREADY = 1'b0;
        tick();
        tick();
        tick();
        chk("mid access", ctl_now(), ctl_exp(1'b1, 1'b1, 1'b1, 32'h0000_0600, 32'h0000_0077, '0, 1'b0));
        RST = 1'b1;
        tick();
        chk("reset mid ctl", ctl_now(), ctl_exp(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0));
        chk("reset mid rdata", 128'(rdata), 128'(0));
        $display("xfer reset mid-access: PSEL=%0d done=%b", PSEL, done);
        RST = 1'b0;
        req = 3'b110;
        set_fields(1, 1'b1, 32'h0000_0608, 32'h0000_0099);
        xfer("post reset", 1, 1'b1, 32'h0000_0608, 32'h0000_0099, 0, 32'h0,
             '0, '0, 1'b0, 32'h0);
        req[1] = 1'b0;
        ptr_m = 2;
        rd_m  = '0;

        // Randomized phase against the transaction-level model.
        for (int it = 0; it < 60; it++) begin
            logic [N-1:0] nreq;
            logic [N-1:0] clr;
            logic [N-1:0] setm;
            int           g;
            int           waits;
            int           sel;
            logic [W-1:0] prd;
            logic         e;

            if (req == '0) begin
                int nidle;
                nidle = $urandom_range(0, 2);
                for (int j = 0; j < nidle; j++) begin
                    PREADY = 1'($urandom_range(0, 1));
                    PRDATA = $urandom;
                    tick();
                    chk($sformatf("rnd%0d idle", it), ctl_now(), ctl_exp(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0));
                end
                nreq = N'($urandom_range(1, (1 << N) - 1));
            end else begin
                nreq = req | N'($urandom_range(0, (1 << N) - 1));
            end
            for (int i = 0; i < N; i++) begin
                if (!req[i] && nreq[i]) set_fields(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
            end
            req = nreq;
            g   = rr_pick(req, ptr_m);

            sel = $urandom_range(0, 9);
            if (sel <= 5)      waits = $urandom_range(0, 3);
            else if (sel == 6) waits = TO - 2;
            else if (sel == 7) waits = TO - 1;
            else if (sel == 8) waits = TO;
            else               waits = TO + $urandom_range(1, 4);
            prd = $urandom;

            clr  = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
            setm = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
            for (int i = 0; i < N; i++) begin
                if (setm[i] && !req[i]) set_fields(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
            end

            e = (waits >= TO);
            if (e)           rd_m = '0;
            else if (!w_v[g]) rd_m = prd;

            xfer($sformatf("rnd%0d", it), g, w_v[g], a_v[g], d_v[g], waits, prd,
                 clr, setm, e, rd_m);
            ptr_m  = (g + 1) % N;
            req[g] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
